hfg_rec_sched: RTL and testbench

Sequencer for the 8-lane Haar rectangle unit (`hfg_8wayrec`). On `iStart` it walks a list of rectangle descriptors and fetches each rectangle's four corner values from the integral-image window buffer. It packs up to eight rectangles into the 84-bit lane vectors and issues them with a one-cycle `oReady`. It then flags when the unit's `oRec0..7` outputs are valid and which lanes are meaningful. It sits between the descriptor ROM / window buffer and `hfg_8wayrec`; the stage accumulator consumes its result strobes.

---
 rtl/hfg_rec_sched_if.sv | 39 +++
 rtl/hfg_rec_sched.sv | 158 +++++++++++++++
 tb/tb_hfg_rec_sched.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/hfg_rec_sched_if.sv
// Signal bundle between hfg_rec_sched, the descriptor ROM, the window buffer and hfg_8wayrec.
// oReady is a one-cycle issue strobe with no back-pressure; the consumer must take the lanes that cycle.
interface hfg_rec_sched_if;
    logic        iStart;
    logic [7:0]  iNumRec;
    logic [7:0]  oDescAddr;
    logic [40:0] iDescData;
    logic [9:0]  oIiAddr;
    logic [20:0] iIiData;
    logic [83:0] o4Rec0;
    logic [83:0] o4Rec1;
    logic [83:0] o4Rec2;
    logic [83:0] o4Rec3;
    logic [83:0] o4Rec4;
    logic [83:0] o4Rec5;
    logic [83:0] o4Rec6;
    logic [83:0] o4Rec7;
    logic [7:0]  oSign;
    logic        oReady;
    logic        oResValid;
    logic [7:0]  oResMask;
    logic        oBusy;
    logic        oDone;
    logic [3:0]  state_dbg;

    modport master (
        input  iStart, iNumRec, iDescData, iIiData,
        output oDescAddr, oIiAddr, o4Rec0, o4Rec1, o4Rec2, o4Rec3,
               o4Rec4, o4Rec5, o4Rec6, o4Rec7, oSign, oReady,
               oResValid, oResMask, oBusy, oDone, state_dbg
    );

    modport slave (
        output iStart, iNumRec, iDescData, iIiData,
        input  oDescAddr, oIiAddr, o4Rec0, o4Rec1, o4Rec2, o4Rec3,
               o4Rec4, o4Rec5, o4Rec6, o4Rec7, oSign, oReady,
               oResValid, oResMask, oBusy, oDone, state_dbg
    );
endinterface

// File: rtl/hfg_rec_sched.sv
// Walks the rectangle descriptor list, fetches four corners per rectangle into eight lanes,
// issues full or final batches to hfg_8wayrec and flags its results REC_LAT cycles later.
module hfg_rec_sched #(
    parameter int REC_LAT = 2
) (
    input logic             iClk,
    input logic             iReset_n,
    hfg_rec_sched_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_DESC, S_C0, S_C1, S_C2, S_C3, S_CAP, S_ISSUE, S_DRAIN
    } state_t;

    state_t             state;
    logic [7:0]         num_q;
    logic [7:0]         rec_idx;
    logic [2:0]         lane;
    logic [19:0]        desc_cd_q;
    logic [9:0]         ii_addr_q;
    logic [83:0]        lane_q [8];
    logic [7:0]         sign_q;
    logic [7:0]         pend_q;
    logic               ready_q;
    logic               busy_q;
    logic               zero_done_q;
    logic [REC_LAT-1:0] dl_v;
    logic [REC_LAT-1:0] dl_l;
    logic [7:0]         dl_m [REC_LAT];
    logic               more;
    logic               done_w;

    // True while rectangles beyond the current index are still to be fetched.
    assign more   = ({1'b0, rec_idx} + 9'd1) < {1'b0, num_q};
    assign done_w = dl_l[REC_LAT-1] | zero_done_q;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state       <= S_IDLE;
            num_q       <= '0;
            rec_idx     <= '0;
            lane        <= '0;
            desc_cd_q   <= '0;
            ii_addr_q   <= '0;
            sign_q      <= '0;
            pend_q      <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            zero_done_q <= 1'b0;
            dl_v        <= '0;
            dl_l        <= '0;
            for (int i = 0; i < 8; i++) lane_q[i] <= '0;
            for (int i = 0; i < REC_LAT; i++) dl_m[i] <= '0;
        end else begin
            ready_q     <= 1'b0;
            zero_done_q <= 1'b0;
            // Result delay line: an entry is loaded only in the ISSUE cycle.
            dl_v[0] <= (state == S_ISSUE);
            dl_l[0] <= (state == S_ISSUE) && !more;
            dl_m[0] <= (state == S_ISSUE) ? pend_q : 8'h00;
            for (int i = 1; i < REC_LAT; i++) begin
                dl_v[i] <= dl_v[i-1];
                dl_l[i] <= dl_l[i-1];
                dl_m[i] <= dl_m[i-1];
            end
            case (state)
                S_IDLE: begin
                    if (bus.iStart) begin
                        num_q   <= bus.iNumRec;
                        rec_idx <= '0;
                        lane    <= '0;
                        sign_q  <= '0;
                        pend_q  <= '0;
                        busy_q  <= 1'b1;
                        for (int i = 0; i < 8; i++) lane_q[i] <= '0;
                        if (bus.iNumRec == 8'd0) begin
                            zero_done_q <= 1'b1;
                            state       <= S_DRAIN;
                        end else begin
                            state <= S_DESC;
                        end
                    end
                end
                S_DESC: state <= S_C0;
                S_C0: begin
                    desc_cd_q    <= bus.iDescData[39:20];
                    ii_addr_q    <= bus.iDescData[19:10];
                    sign_q[lane] <= bus.iDescData[40];
                    state        <= S_C1;
                end
                S_C1: begin
                    lane_q[lane][20:0] <= bus.iIiData;
                    ii_addr_q          <= desc_cd_q[9:0];
                    state              <= S_C2;
                end
                S_C2: begin
                    lane_q[lane][41:21] <= bus.iIiData;
                    ii_addr_q           <= desc_cd_q[19:10];
                    state               <= S_C3;
                end
                S_C3: begin
                    lane_q[lane][62:42] <= bus.iIiData;
                    state               <= S_CAP;
                end
                S_CAP: begin
                    lane_q[lane][83:63] <= bus.iIiData;
                    pend_q[lane]        <= 1'b1;
                    if (lane != 3'd7 && more) begin
                        rec_idx <= rec_idx + 8'd1;
                        lane    <= lane + 3'd1;
                        state   <= S_DESC;
                    end else begin
                        ready_q <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (more) begin
                        // Next batch starts clean so unused lanes of a partial batch read 0.
                        rec_idx <= rec_idx + 8'd1;
                        lane    <= '0;
                        sign_q  <= '0;
                        pend_q  <= '0;
                        for (int i = 0; i < 8; i++) lane_q[i] <= '0;
                        state   <= S_DESC;
                    end else begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (done_w) begin
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Window address is live from the descriptor in C0 so corner A returns in C1.
    assign bus.oIiAddr   = (state == S_C0) ? bus.iDescData[9:0] : ii_addr_q;
    assign bus.oDescAddr = rec_idx;
    assign bus.o4Rec0    = lane_q[0];
    assign bus.o4Rec1    = lane_q[1];
    assign bus.o4Rec2    = lane_q[2];
    assign bus.o4Rec3    = lane_q[3];
    assign bus.o4Rec4    = lane_q[4];
    assign bus.o4Rec5    = lane_q[5];
    assign bus.o4Rec6    = lane_q[6];
    assign bus.o4Rec7    = lane_q[7];
    assign bus.oSign     = sign_q;
    assign bus.oReady    = ready_q;
    assign bus.oResValid = dl_v[REC_LAT-1];
    assign bus.oResMask  = dl_m[REC_LAT-1];
    assign bus.oBusy     = busy_q;
    assign bus.oDone     = done_w;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_hfg_rec_sched.sv
// Directed bench for hfg_rec_sched: ROM/window-buffer responders, per-cycle event recorder,
// hand-computed expectations for batch timing, lane packing, masks and reset abort.
module tb_hfg_rec_sched;
    logic iClk;
    logic iReset_n;

    hfg_rec_sched_if bus ();

    hfg_rec_sched #(.REC_LAT(2)) dut (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .bus      (bus)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int          checks;
    int          errors;
    int          cyc;
    logic [7:0]  sgn_pat;
    int          rdy_q[$];
    int          vld_q[$];
    int          done_cq[$];
    logic [7:0]  mask_q[$];
    logic [7:0]  sgn_q[$];
    logic [83:0] rec0_q[$];
    logic [83:0] rec3_q[$];
    logic [83:0] hi_q[$];
    logic [7:0]  exp_q[$];
    int          busy_cnt;
    int          busy_first;
    int          busy_last;
    int          bad_mask;

    localparam logic [83:0] REC_R0 = {21'h10004, 21'h10003, 21'h10002, 21'h10001};
    localparam logic [83:0] REC_R3 = {21'h10010, 21'h1000F, 21'h1000E, 21'h1000D};
    localparam logic [83:0] REC_R8 = {21'h10024, 21'h10023, 21'h10022, 21'h10021};

    // Descriptor r: corners at window addresses 4r+1..4r+4, sign from the lane pattern.
    function automatic logic [40:0] desc_of(input logic [7:0] r);
        logic [9:0] base;
        base = {r, 2'b00};
        return {sgn_pat[r[2:0]], base + 10'd4, base + 10'd3, base + 10'd2, base + 10'd1};
    endfunction

    always @(posedge iClk) begin
        bus.iDescData <= desc_of(bus.oDescAddr);
        bus.iIiData   <= 21'h10000 + {11'h000, bus.oIiAddr};
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rec();
        rdy_q.delete();
        vld_q.delete();
        done_cq.delete();
        mask_q.delete();
        sgn_q.delete();
        rec0_q.delete();
        rec3_q.delete();
        hi_q.delete();
        exp_q.delete();
        busy_cnt   = 0;
        busy_first = -1;
        busy_last  = -1;
        bad_mask   = 0;
    endtask

    task automatic start_run(input logic [7:0] n);
        clear_rec();
        @(negedge iClk);
        bus.iStart  = 1'b1;
        bus.iNumRec = n;
        cyc = 0;
    endtask

    task automatic watch(input int ncyc, input int repulse_at);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge iClk);
            cyc++;
            bus.iStart = (cyc == repulse_at);
            if (bus.oReady) begin
                rdy_q.push_back(cyc);
                sgn_q.push_back(bus.oSign);
                rec0_q.push_back(bus.o4Rec0);
                rec3_q.push_back(bus.o4Rec3);
                hi_q.push_back(bus.o4Rec3 | bus.o4Rec4 | bus.o4Rec5 | bus.o4Rec6 | bus.o4Rec7);
            end
            if (bus.oResValid) begin
                vld_q.push_back(cyc);
                mask_q.push_back(bus.oResMask);
            end else if (bus.oResMask != 8'h00) begin
                bad_mask++;
            end
            if (bus.oDone) done_cq.push_back(cyc);
            if (bus.oBusy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
            end
        end
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_outs"}, {bus.oDescAddr, bus.oIiAddr, bus.oSign, bus.oReady, bus.oResValid,
                               bus.oResMask, bus.oBusy, bus.oDone}, 0);
        check({tag, "_lanes"}, bus.o4Rec0 | bus.o4Rec1 | bus.o4Rec2 | bus.o4Rec3 |
                               bus.o4Rec4 | bus.o4Rec5 | bus.o4Rec6 | bus.o4Rec7, 0);
    endtask

    task automatic check_full8(input string tag);
        check({tag, "_rdy_n"}, rdy_q.size(), 1);
        if (rdy_q.size() > 0) begin
            check({tag, "_rdy_cyc"}, rdy_q[0], 49);
            check({tag, "_rec0"}, rec0_q[0], REC_R0);
            check({tag, "_rec3"}, rec3_q[0], REC_R3);
            check({tag, "_sign"}, sgn_q[0], 8'hA5);
        end
        exp_q.push_back(8'hFF);
        check({tag, "_vld_n"}, vld_q.size(), 1);
        if (vld_q.size() > 0) begin
            check({tag, "_vld_cyc"}, vld_q[0], 51);
            check({tag, "_mask"}, mask_q[0], exp_q.pop_front());
        end
        check({tag, "_done_n"}, done_cq.size(), 1);
        if (done_cq.size() > 0) check({tag, "_done_cyc"}, done_cq[0], 51);
        check({tag, "_busy_first"}, busy_first, 1);
        check({tag, "_busy_last"}, busy_last, 51);
        check({tag, "_bad_mask"}, bad_mask, 0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        sgn_pat     = 8'hA5;
        iReset_n    = 1'b0;
        bus.iStart  = 1'b0;
        bus.iNumRec = 8'd0;
        clear_rec();
        repeat (3) @(negedge iClk);
        iReset_n = 1'b1;
        @(negedge iClk);
        check_outs_zero("reset");

        // Full batch of eight.
        start_run(8'd8);
        watch(56, -1);
        check_full8("t8");

        // Partial batch of three: unused lanes must read zero.
        start_run(8'd3);
        watch(25, -1);
        check("t3_rdy_n", rdy_q.size(), 1);
        if (rdy_q.size() > 0) begin
            check("t3_rdy_cyc", rdy_q[0], 19);
            check("t3_rec0", rec0_q[0], REC_R0);
            check("t3_hi_zero", hi_q[0], 0);
            check("t3_sign", sgn_q[0], 8'h05);
        end
        check("t3_vld_n", vld_q.size(), 1);
        if (vld_q.size() > 0) begin
            check("t3_vld_cyc", vld_q[0], 21);
            check("t3_mask", mask_q[0], 8'h07);
        end
        check("t3_done_n", done_cq.size(), 1);
        if (done_cq.size() > 0) check("t3_done_cyc", done_cq[0], 21);

        // Eleven rectangles: a full batch then a batch of three.
        start_run(8'd11);
        watch(75, -1);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h07);
        check("t11_rdy_n", rdy_q.size(), 2);
        if (rdy_q.size() > 1) begin
            check("t11_rdy0_cyc", rdy_q[0], 49);
            check("t11_rdy1_cyc", rdy_q[1], 68);
            check("t11_rec0_b2", rec0_q[1], REC_R8);
            check("t11_hi_zero_b2", hi_q[1], 0);
            check("t11_sign_b2", sgn_q[1], 8'h05);
        end
        check("t11_vld_n", vld_q.size(), 2);
        if (vld_q.size() > 1) begin
            check("t11_vld0_cyc", vld_q[0], 51);
            check("t11_mask0", mask_q[0], exp_q.pop_front());
            check("t11_vld1_cyc", vld_q[1], 70);
            check("t11_mask1", mask_q[1], exp_q.pop_front());
        end
        check("t11_done_n", done_cq.size(), 1);
        if (done_cq.size() > 0) check("t11_done_cyc", done_cq[0], 70);
        check("t11_busy_last", busy_last, 70);
        check("t11_bad_mask", bad_mask, 0);

        // Zero rectangles: immediate done, no issue.
        start_run(8'd0);
        watch(5, -1);
        check("t0_rdy_n", rdy_q.size(), 0);
        check("t0_vld_n", vld_q.size(), 0);
        check("t0_done_n", done_cq.size(), 1);
        if (done_cq.size() > 0) check("t0_done_cyc", done_cq[0], 1);
        check("t0_busy_cnt", busy_cnt, 1);

        // Start re-pulsed mid-run is ignored.
        start_run(8'd8);
        watch(60, 20);
        check_full8("trep");

        // Reset mid-run aborts; no strobes afterwards.
        start_run(8'd8);
        watch(29, -1);
        @(negedge iClk);
        iReset_n = 1'b0;
        #1;
        check_outs_zero("abort");
        @(negedge iClk);
        iReset_n = 1'b1;
        cyc = 0;
        watch(30, -1);
        check("abort_rdy_n", rdy_q.size(), 0);
        check("abort_vld_n", vld_q.size(), 0);
        check("abort_done_n", done_cq.size(), 0);
        check("abort_busy_last", busy_last, 29);

        // A fresh run after the abort behaves normally.
        start_run(8'd8);
        watch(56, -1);
        check_full8("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
